// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, phase scaling and the constant
// tables used by both the rotation and vectoring directions.
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    // pi * 2^30, the scale used for the integer arctangent series
    localparam longint PI_Q30 = 64'sd3373259426;

    // Phase word value of pi: the full phase range is [-pi, pi)
    function automatic longint pi(input int wdt);
        return longint'(1) << (wdt + 1);
    endfunction

    // Phase word value of pi/2
    function automatic longint pi_2(input int wdt);
        return longint'(1) << wdt;
    endfunction

    // round(atan(2^-i) * 2^(wdt+1) / pi), evaluated with an integer Taylor
    // series at 2^-30 resolution so it stays usable as a constant function
    function automatic longint atan_lut(input int i, input int wdt);
        longint t;
        longint pw;
        longint acc;
        longint res;
        if (i == 0) begin
            res = longint'(1) << (wdt - 1);
        end else if (i > 30) begin
            res = 0;
        end else begin
            t   = longint'(1) << (30 - i);
            pw  = t;
            acc = 0;
            for (int k = 0; k < 24; k++) begin
                if (k % 2 == 0) acc = acc + pw / longint'(2 * k + 1);
                else            acc = acc - pw / longint'(2 * k + 1);
                pw = (((pw * t) >>> 30) * t) >>> 30;
            end
            res = ((acc << (wdt + 2)) + PI_Q30) / (2 * PI_Q30);
        end
        return res;
    endfunction

    // round(2^(wdt+2) / 1.646760258): inverse CORDIC gain
    function automatic longint kinv(input int wdt);
        return ((longint'(1) << (wdt + 2)) * 64'sd1000000000 + 64'sd823380129)
               / 64'sd1646760258;
    endfunction

endpackage

// File: rtl/cordic_pol2rect_if.sv
// Handshake and data bundle between a CORDIC requester and the converter.
interface cordic_pol2rect_if #(
    parameter int XY_WDT = 16
);
    logic                     sclr;
    logic                     en;
    logic                     st;
    logic                     rdy;
    logic [XY_WDT-1:0]        mag;
    logic signed [XY_WDT+1:0] ph;
    logic signed [XY_WDT:0]   xout;
    logic signed [XY_WDT:0]   yout;

    modport master (output sclr, en, st, mag, ph, input rdy, xout, yout);
    modport slave  (input sclr, en, st, mag, ph, output rdy, xout, yout);
endinterface

// File: rtl/cordic_rot_stage.sv
// One combinational CORDIC micro-rotation, steered by the sign of z.
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter  int XY_WDT = 16,
    parameter  int N      = 16,
    localparam int XW     = XY_WDT + 4,
    localparam int ZW     = XY_WDT + 2,
    localparam int CW     = $clog2(N)
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic signed [ZW-1:0] z,
    input  logic [CW-1:0]        i,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next,
    output logic signed [ZW-1:0] z_next
);

    // Table covers every counter code so the lookup never leaves the array
    logic signed [ZW-1:0] atan_tab [2**CW];

    for (genvar g = 0; g < 2**CW; g++) begin : g_atan
        assign atan_tab[g] = ZW'(atan_lut(g, XY_WDT));
    end

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] atan_i;
    logic                 z_neg;

    assign x_sh   = x >>> i;
    assign y_sh   = y >>> i;
    assign atan_i = atan_tab[i];
    assign z_neg  = z[ZW-1];

    // d = -1 when the residual angle is negative, +1 otherwise
    assign x_next = z_neg ? x + y_sh   : x - y_sh;
    assign y_next = z_neg ? y - x_sh   : y + x_sh;
    assign z_next = z_neg ? z + atan_i : z - atan_i;

endmodule

// File: rtl/cordic_pol2rect.sv
// Serial rotation-mode CORDIC: (magnitude, phase) -> (x, y), one
// micro-rotation per enabled clock.
module cordic_pol2rect
    import cordic_pkg::*;
#(
    parameter string CORDIC_TYPE = "SERIAL",
    parameter int    N           = 16,
    parameter int    XY_WDT      = 16
) (
    input logic              clk,
    input logic              reset,
    cordic_pol2rect_if.slave bus
);

    localparam int XW = XY_WDT + 4;
    localparam int ZW = XY_WDT + 2;
    localparam int OW = XY_WDT + 1;
    localparam int CW = $clog2(N);
    localparam int PW = 2 * XY_WDT + 2;

    if (CORDIC_TYPE != "SERIAL") begin : g_bad_type
        $error("cordic_pol2rect: CORDIC_TYPE must be \"SERIAL\"");
    end
    if (N < 8 || N > XY_WDT + 1) begin : g_bad_n
        $error("cordic_pol2rect: N must lie in 8..XY_WDT+1");
    end

    localparam logic [XY_WDT+1:0]   KINV_Q   = (XY_WDT + 2)'(kinv(XY_WDT));
    localparam logic [PW-1:0]       GAIN_RND = PW'(1) << (XY_WDT - 1);
    localparam logic signed [ZW:0]  PH_PI    = (ZW + 1)'(pi(XY_WDT));
    localparam logic signed [ZW:0]  PH_PI_2  = (ZW + 1)'(pi_2(XY_WDT));
    localparam logic signed [XW:0]  SAT_MAX  = (XW + 1)'((longint'(1) << XY_WDT) - 1);
    localparam logic signed [XW:0]  SAT_MIN  = -SAT_MAX;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic signed [XW-1:0] x_q;
    logic signed [XW-1:0] y_q;
    logic signed [ZW-1:0] z_q;
    logic signed [OW-1:0] xout_q;
    logic signed [OW-1:0] yout_q;

    // Drop the two guard bits (half-up) and clamp to +/-(2^XY_WDT - 1)
    function automatic logic signed [OW-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] r;
        r = (XW + 1)'(v) + (XW + 1)'(2);
        r = r >>> 2;
        if (r > SAT_MAX)      round_sat = SAT_MAX[OW-1:0];
        else if (r < SAT_MIN) round_sat = SAT_MIN[OW-1:0];
        else                  round_sat = r[OW-1:0];
    endfunction

    // LOAD: gain compensation on the captured magnitude held in x_q
    logic [PW-1:0]        gain_prod;
    logic signed [XW-1:0] x_gain;
    logic signed [XW-1:0] x_load;
    assign gain_prod = x_q[XY_WDT-1:0] * KINV_Q + GAIN_RND;
    assign x_gain    = {2'b00, gain_prod[PW-1:XY_WDT]};

    // LOAD: fold phases outside [-pi/2, pi/2] by half a turn, negating x
    logic signed [ZW:0]   z_ext;
    logic signed [ZW-1:0] z_fold;
    logic                 fold_pos;
    logic                 fold_neg;
    assign z_ext    = {z_q[ZW-1], z_q};
    assign fold_pos = z_ext > PH_PI_2;
    assign fold_neg = z_ext < -PH_PI_2;
    assign x_load   = (fold_pos || fold_neg) ? -x_gain : x_gain;

    // Fold the captured phase into the right half-plane
    always_comb begin
        z_fold = z_q;
        if (fold_pos)      z_fold = ZW'(z_ext - PH_PI);
        else if (fold_neg) z_fold = ZW'(z_ext + PH_PI);
    end

    logic signed [XW-1:0] x_rot;
    logic signed [XW-1:0] y_rot;
    logic signed [ZW-1:0] z_rot;

    cordic_rot_stage #(.XY_WDT(XY_WDT), .N(N)) u_rot (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .i      (cnt),
        .x_next (x_rot),
        .y_next (y_rot),
        .z_next (z_rot)
    );

    // State register; clear wins over enable
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || bus.sclr) state <= IDLE;
        else if (bus.en)       state <= state_next;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (bus.st) state_next = LOAD;
            LOAD:    state_next = ITER;
            ITER:    if (cnt == CW'(N - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, load, iterate, then publish the rounded result
    always_ff @(posedge clk) begin
        if (reset || bus.sclr) begin
            cnt    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            xout_q <= '0;
            yout_q <= '0;
        end else if (bus.en) begin
            unique case (state)
                IDLE: if (bus.st) begin
                    x_q <= XW'(bus.mag);
                    z_q <= bus.ph;
                end
                LOAD: begin
                    x_q <= x_load;
                    y_q <= '0;
                    z_q <= z_fold;
                    cnt <= '0;
                end
                ITER: begin
                    x_q <= x_rot;
                    y_q <= y_rot;
                    z_q <= z_rot;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    xout_q <= round_sat(x_q);
                    yout_q <= round_sat(y_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy  = (state == IDLE);
    assign bus.xout = xout_q;
    assign bus.yout = yout_q;

endmodule
